// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : id_ex_stage_pkg                                             |
// | Desc   : Control-bundle layout and bubble constant for ID/EX stage.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package id_ex_stage_pkg;

    localparam int CTRL_W = 10;

    // Bit positions in {RegWrite, MemtoReg, MemRead, MemWrite, Branch,
    // ALUSrc, RegDst, Jump, ALUOp[1:0]}
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : load_use_detect                                             |
// | Desc   : Combinational load-use hazard detection for ID/EX.          |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module load_use_detect (
    input  logic       i_reset,
    input  logic       i_hold,
    input  logic       i_flush,
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_stall
);

    logic w_match;

    // $zero never carries a real dependency
    assign w_match = (i_ex_rt != 5'd0) &&
                     ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

    assign o_stall = !i_reset && i_ex_valid && i_ex_memread && w_match &&
                     !i_hold && !i_flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : id_ex_stage                                                 |
// | Desc   : ID/EX pipeline register with hold, flush, load-use bubble.  |
// |          Optional StallCount port under macro HAZARD_STATS_EN.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Hold,
    input  logic              Flush,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PC4,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [DATA_W-1:0] EX_PC4,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic              EX_Valid,
`ifdef HAZARD_STATS_EN
    output logic [31:0]       StallCount,
`endif
    output logic              Stall
);

    logic [DATA_W-1:0] r_rd1, r_rd2, r_imm, r_pc4;
    logic [4:0]        r_rs, r_rt, r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;
    logic              r_flush_pend;
    logic              w_stall;
    logic              w_bubble;

    load_use_detect u_load_use_detect (
        .i_reset      (reset),
        .i_hold       (Hold),
        .i_flush      (Flush),
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl[CTRL_MEMREAD]),
        .i_ex_rt      (r_rt),
        .i_id_rs      (ID_Rs),
        .i_id_rt      (ID_Rt),
        .o_stall      (w_stall)
    );

    // Only evaluated when Hold=0; a flush (live or pending) outranks a stall
    assign w_bubble = Flush || r_flush_pend || w_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc4   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= CTRL_BUBBLE;
            r_valid <= 1'b0;
        end else if (!Hold) begin
            if (w_bubble) begin
                r_rd1   <= '0;
                r_rd2   <= '0;
                r_imm   <= '0;
                r_pc4   <= '0;
                r_rs    <= '0;
                r_rt    <= '0;
                r_rd    <= '0;
                r_ctrl  <= CTRL_BUBBLE;
                r_valid <= 1'b0;
            end else begin
                r_rd1   <= ID_ReadData1;
                r_rd2   <= ID_ReadData2;
                r_imm   <= ID_Imm;
                r_pc4   <= ID_PC4;
                r_rs    <= ID_Rs;
                r_rt    <= ID_Rt;
                r_rd    <= ID_Rd;
                r_ctrl  <= ID_Ctrl;
                r_valid <= 1'b1;
            end
        end
    end

    // A flush seen while frozen is remembered until the first unfrozen edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_pend <= 1'b0;
        end else if (Hold) begin
            if (Flush) begin
                r_flush_pend <= 1'b1;
            end
        end else begin
            r_flush_pend <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && !r_flush_pend && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign StallCount = r_stall_count;
`endif

    assign EX_ReadData1 = r_rd1;
    assign EX_ReadData2 = r_rd2;
    assign EX_Imm       = r_imm;
    assign EX_PC4       = r_pc4;
    assign EX_Rs        = r_rs;
    assign EX_Rt        = r_rt;
    assign EX_Rd        = r_rd;
    assign EX_Ctrl      = r_ctrl;
    assign EX_Valid     = r_valid;
    assign Stall        = w_stall;

endmodule
`default_nettype wire
